// File: rtl/uart_rx.sv
// uart_rx: UART receiver driven by a 16x (OVERSAMPLE) rx_enable tick.
// Synchronises rx, qualifies the start bit at mid-bit, samples LSB-first
// data at mid-bit, checks the stop bit and hands the byte to the host via a
// sticky rx_valid / rx_ack handshake. Flags framing errors and overruns.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and a parity_err output.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_enable,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] TICK_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE       = TW'(1);
    localparam logic [BW-1:0] BIT_LAST       = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE        = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity holds when data bits and parity bit XOR to zero.
    function automatic logic even_parity_ok(input logic [DATA_BITS-1:0] d,
                                            input logic                 p);
        return ~((^d) ^ p);
    endfunction
`endif

    logic [1:0]           sync_q;
    logic                 rx_s;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
    logic                 good_s;
`ifdef UART_RX_PARITY_EN
    logic                 perr_q, perr_d;
    logic                 par_bad_q, par_bad_d;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Next-state logic: frame sequencing on rx_enable ticks plus handshake/flags.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        good_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        if (rx_enable) begin
            case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                    if (!rx_s) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (tick_q == TICK_HALF_LAST) begin
                        tick_d = '0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            // Start bit vanished before mid-bit: treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                S_DATA: begin
                    if (tick_q == TICK_FULL_LAST) begin
                        tick_d  = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_q == TICK_FULL_LAST) begin
                        tick_d    = '0;
                        par_bad_d = ~even_parity_ok(shift_q, rx_s);
                        state_d   = S_STOP;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (tick_q == TICK_FULL_LAST) begin
                        tick_d  = '0;
                        state_d = S_IDLE;
                        if (!rx_s) begin
                            // Framing error wins over any parity mismatch.
                            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad_q) begin
                            perr_d = 1'b1;
`endif
                        end else begin
                            good_s = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tick_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
            tick_d  = tick_q;
        end

        if (good_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (rx_ack) begin
            data_d  = data_q;
            valid_d = 1'b0;
        end else begin
            data_d  = data_q;
            valid_d = valid_q;
        end

        // Overrun only when the old byte is still unconsumed this very cycle.
        ovr_d  = good_s & valid_q & ~rx_ack;
        busy_d = (state_d != S_IDLE);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch latch and its registered error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

    assign data_out  = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;

endmodule
